// File: rtl/fp2int_pkg.sv
// ---------------------------------------------------------------------------
// fp2int_pkg
// Shared definitions for the multi-cycle float-to-int converter:
//   - state_t : FSM state encoding (IDLE, CLASS, SHIFT, SIGN, DONE)
//   - FP_BIAS, EXP_MAX : IEEE-754 single exponent bias and all-ones exponent
//   - INT_MAX, INT_MIN : saturation values for a signed 32-bit result
//   - INT_MIN_FLOAT    : the float -2^31, the only e>=31 value that fits
// No ports (package).
// ---------------------------------------------------------------------------
package fp2int_pkg;

    localparam logic signed [8:0] FP_BIAS       = 9'sd127;
    localparam logic [7:0]        EXP_MAX       = 8'hFF;
    localparam logic [31:0]       INT_MAX       = 32'h7FFF_FFFF;
    localparam logic [31:0]       INT_MIN       = 32'h8000_0000;
    localparam logic [31:0]       INT_MIN_FLOAT = 32'hCF00_0000;

    typedef enum logic [2:0] {
        IDLE,
        CLASS,
        SHIFT,
        SIGN,
        DONE
    } state_t;

endpackage

// File: rtl/fp2int_classify.sv
// ---------------------------------------------------------------------------
// fp2int_classify
// Combinational decode of a single-precision operand for the converter.
// Decides whether the result is known immediately (zero, too small,
// Inf/NaN, out of range) and, if not, how far and in which direction the
// 24-bit mantissa has to be shifted to land on the integer value.
// Ports:
//   num         in  32  float operand {sign, exp, frac}
//   int_i       in  1   integral flag from the fraction checker
//   special     out 1   result is final, skip shifting
//   spec_result out 32  result for the special case
//   spec_ovf    out 1   saturation flag for the special case
//   spec_exact  out 1   exactness flag for the special case
//   shift_cnt   out 5   number of single-bit shifts needed (normal case)
//   shift_left  out 1   1 = shift left, 0 = shift right
// ---------------------------------------------------------------------------
module fp2int_classify
    import fp2int_pkg::*;
(
    input  logic [31:0] num,
    input  logic        int_i,
    output logic        special,
    output logic [31:0] spec_result,
    output logic        spec_ovf,
    output logic        spec_exact,
    output logic [4:0]  shift_cnt,
    output logic        shift_left
);

    logic              sign;
    logic [7:0]        exp_f;
    logic [22:0]       frac;
    logic signed [8:0] e;

    assign sign  = num[31];
    assign exp_f = num[30:23];
    assign frac  = num[22:0];
    assign e     = $signed({1'b0, exp_f}) - FP_BIAS;

    // Priority matters: exp==0 also yields e<0, and must be checked first so a
    // true zero can still be reported exact.
    always_comb begin
        special     = 1'b0;
        spec_result = 32'd0;
        spec_ovf    = 1'b0;
        spec_exact  = 1'b0;
        shift_cnt   = 5'd0;
        shift_left  = 1'b0;
        if (exp_f == EXP_MAX) begin
            special  = 1'b1;
            spec_ovf = 1'b1;
            if (frac != 23'd0) begin
                spec_result = INT_MIN;
            end else begin
                spec_result = sign ? INT_MIN : INT_MAX;
            end
        end else if (exp_f == 8'd0) begin
            // Only a true zero loses no bits; any denormal truncates to 0.
            special    = 1'b1;
            spec_exact = int_i && (frac == 23'd0);
        end else if (e < 9'sd0) begin
            special = 1'b1;
        end else if (e >= 9'sd31) begin
            special = 1'b1;
            if (num == INT_MIN_FLOAT) begin
                spec_result = INT_MIN;
                spec_exact  = int_i;
            end else begin
                spec_result = sign ? INT_MIN : INT_MAX;
                spec_ovf    = 1'b1;
            end
        end else if (e > 9'sd23) begin
            shift_left = 1'b1;
            shift_cnt  = e[4:0] - 5'd23;
        end else begin
            shift_cnt  = 5'd23 - e[4:0];
        end
    end

endmodule

// File: rtl/fp2int_fsm.sv
// ---------------------------------------------------------------------------
// fp2int_fsm
// Multi-cycle IEEE-754 single -> signed 32-bit integer converter. The
// mantissa is shifted one bit per clock into place; the result saturates on
// overflow, Inf and NaN. Start/done use single-cycle r_i/r_o pulses.
// Optional feature: define FP2INT_ROUND_EN to round half away from zero
// (adds the last shifted-out bit); otherwise the result truncates toward zero.
// Ports:
//   clk      in  1   rising-edge clock
//   rst_n    in  1   asynchronous active-low reset
//   r_i      in  1   start pulse, only sampled in IDLE
//   num_in   in  32  float operand
//   int_i    in  1   checker flag: operand is integral
//   int_out  out 32  converted integer, held until rewritten
//   ovf      out 1   saturation occurred
//   exact    out 1   int_i and no overflow and no nonzero bits lost
//   busy     out 1   operation in progress (through the r_o cycle)
//   r_o      out 1   one-cycle done pulse
// ---------------------------------------------------------------------------
module fp2int_fsm
    import fp2int_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int OUT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   r_i,
    input  logic [EXP_W+MAN_W:0]   num_in,
    input  logic                   int_i,
    output logic [OUT_W-1:0]       int_out,
    output logic                   ovf,
    output logic                   exact,
    output logic                   busy,
    output logic                   r_o
);

    state_t      state_q, state_d;
    logic [31:0] num_q, num_d;
    logic        int_i_q, int_i_d;
    logic [31:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        left_q, left_d;
    logic        sticky_q, sticky_d;
    logic [31:0] int_out_q, int_out_d;
    logic        ovf_q, ovf_d;
    logic        exact_q, exact_d;

    logic        special;
    logic [31:0] spec_result;
    logic        spec_ovf;
    logic        spec_exact;
    logic [4:0]  shift_cnt;
    logic        shift_left;
    logic        round_bit;
    logic [31:0] mag;

    fp2int_classify u_classify (
        .num         (num_q),
        .int_i       (int_i_q),
        .special     (special),
        .spec_result (spec_result),
        .spec_ovf    (spec_ovf),
        .spec_exact  (spec_exact),
        .shift_cnt   (shift_cnt),
        .shift_left  (shift_left)
    );

`ifdef FP2INT_ROUND_EN
    logic guard_q, guard_d;

    // Guard is the most recent bit pushed out by a right shift; it is the
    // half-LSB used for rounding. Left shifts never drop set bits.
    always_comb begin
        guard_d = guard_q;
        if (state_q == CLASS) begin
            guard_d = 1'b0;
        end else if (state_q == SHIFT && !left_q) begin
            guard_d = acc_q[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            guard_q <= 1'b0;
        end else begin
            guard_q <= guard_d;
        end
    end

    assign round_bit = guard_q;
`else
    assign round_bit = 1'b0;
`endif

    // Next-state and datapath. Right-shifted magnitudes are below 2^24, so
    // adding the round bit cannot overflow before negation.
    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        int_i_d   = int_i_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        left_d    = left_q;
        sticky_d  = sticky_q;
        int_out_d = int_out_q;
        ovf_d     = ovf_q;
        exact_d   = exact_q;
        mag       = acc_q + {31'd0, round_bit};
        case (state_q)
            IDLE: begin
                if (r_i) begin
                    num_d   = num_in;
                    int_i_d = int_i;
                    state_d = CLASS;
                end
            end
            CLASS: begin
                if (special) begin
                    int_out_d = spec_result;
                    ovf_d     = spec_ovf;
                    exact_d   = spec_exact;
                    state_d   = DONE;
                end else begin
                    acc_d    = {8'd0, 1'b1, num_q[22:0]};
                    cnt_d    = shift_cnt;
                    left_d   = shift_left;
                    sticky_d = 1'b0;
                    state_d  = (shift_cnt == 5'd0) ? SIGN : SHIFT;
                end
            end
            SHIFT: begin
                if (left_q) begin
                    acc_d = {acc_q[30:0], 1'b0};
                end else begin
                    acc_d    = {1'b0, acc_q[31:1]};
                    sticky_d = sticky_q | acc_q[0];
                end
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                int_out_d = num_q[31] ? (~mag + 32'd1) : mag;
                ovf_d     = 1'b0;
                exact_d   = int_i_q && !sticky_q;
                state_d   = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state, including the visible result, is cleared by reset so an
    // interrupted operation leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            num_q     <= 32'd0;
            int_i_q   <= 1'b0;
            acc_q     <= 32'd0;
            cnt_q     <= 5'd0;
            left_q    <= 1'b0;
            sticky_q  <= 1'b0;
            int_out_q <= 32'd0;
            ovf_q     <= 1'b0;
            exact_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            int_i_q   <= int_i_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            left_q    <= left_d;
            sticky_q  <= sticky_d;
            int_out_q <= int_out_d;
            ovf_q     <= ovf_d;
            exact_q   <= exact_d;
        end
    end

    assign int_out = int_out_q;
    assign ovf     = ovf_q;
    assign exact   = exact_q;
    assign busy    = (state_q != IDLE);
    assign r_o     = (state_q == DONE);

endmodule
